// File: rtl/ledr_pwm.sv
// Avalon-MM LED bank with per-channel PWM brightness and period-aligned duty updates.
// Define LEDR_PWM_BLINK_EN to build the optional blink divider and BLINK_MASK register.
module ledr_pwm #(
    parameter int CHANNELS      = 10,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 16,
    parameter int ADDR_W        = $clog2(CHANNELS + 3)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                chipselect,
    input  logic [ADDR_W-1:0]   address,
    input  logic                write,
    input  logic [31:0]         writedata,
    input  logic                read,
    output logic [31:0]         readdata,
    output logic [CHANNELS-1:0] ledr
);

    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
    localparam logic [ADDR_W-1:0]   A_CTRL  = ADDR_W'(CHANNELS);
    localparam logic [ADDR_W-1:0]   A_PRE   = ADDR_W'(CHANNELS + 1);

    logic [CHANNELS-1:0][PWM_BITS-1:0] duty_q;
    logic [CHANNELS-1:0][PWM_BITS-1:0] active_q;
    logic                              en_q;
    logic                              inv_q;
    logic [PRESCALE_BITS-1:0]          prescale_q;
    logic [PRESCALE_BITS-1:0]          pre_cnt_q;
    logic [PWM_BITS-1:0]               pwm_cnt_q;
    logic [CHANNELS-1:0]               ledr_q;
    logic [31:0]                       readdata_q;
    logic [31:0]                       rdata_d;
    logic [CHANNELS-1:0]               raw;
    logic [CHANNELS-1:0]               blank;
    logic                              wr_en;
    logic                              tick;
    logic                              wrap;
    logic                              unused_wdata;

    assign wr_en        = chipselect & write;
    assign tick         = en_q & (pre_cnt_q == prescale_q);
    assign wrap         = tick & (pwm_cnt_q == PWM_MAX);
    assign unused_wdata = ^writedata;

`ifdef LEDR_PWM_BLINK_EN
    localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(CHANNELS + 2);

    logic [7:0]          blink_div_q;
    logic [7:0]          blink_cnt_q;
    logic                phase_q;
    logic [CHANNELS-1:0] blink_mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_div_q  <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            blink_mask_q <= '0;
        end else begin
            if (wr_en && address == A_CTRL) blink_div_q <= writedata[15:8];
            if (wr_en && address == A_MASK) blink_mask_q <= writedata[CHANNELS-1:0];
            if (!en_q) begin
                blink_cnt_q <= '0;
                phase_q     <= 1'b0;
            end else if (wrap) begin
                if (blink_cnt_q == blink_div_q) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 8'd1;
                end
            end
        end
    end

    assign blank = phase_q ? blink_mask_q : '0;
`else
    assign blank = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q     <= '0;
            active_q   <= '0;
            en_q       <= 1'b0;
            inv_q      <= 1'b0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && address == ADDR_W'(i)) duty_q[i] <= writedata[PWM_BITS-1:0];
                // Shadow copies in at the period boundary so a running period is never cut short.
                if (!en_q || wrap) active_q[i] <= duty_q[i];
            end
            if (wr_en && address == A_CTRL) begin
                en_q  <= writedata[0];
                inv_q <= writedata[1];
            end
            if (wr_en && address == A_PRE) prescale_q <= writedata[PRESCALE_BITS-1:0];
            if (!en_q) begin
                pre_cnt_q <= '0;
                pwm_cnt_q <= '0;
            end else if (tick) begin
                pre_cnt_q <= '0;
                pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            end else begin
                // Past a lowered PRESCALE this simply runs on to natural overflow.
                pre_cnt_q <= pre_cnt_q + PRESCALE_BITS'(1);
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_raw
        assign raw[gi] = en_q & ~blank[gi] &
                         ((active_q[gi] == PWM_MAX) | (pwm_cnt_q < active_q[gi]));
    end

    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (address == ADDR_W'(i)) rdata_d = 32'(duty_q[i]);
        end
`ifdef LEDR_PWM_BLINK_EN
        if (address == A_CTRL) rdata_d = {16'd0, blink_div_q, 6'd0, inv_q, en_q};
        if (address == A_MASK) rdata_d = 32'(blink_mask_q);
`else
        if (address == A_CTRL) rdata_d = {30'd0, inv_q, en_q};
`endif
        if (address == A_PRE) rdata_d = 32'(prescale_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ledr_q     <= '0;
            readdata_q <= '0;
        end else begin
            ledr_q <= raw ^ {CHANNELS{inv_q}};
            if (chipselect && read) readdata_q <= rdata_d;
        end
    end

    assign ledr     = ledr_q;
    assign readdata = readdata_q;

endmodule

// File: tb/tb_ledr_pwm.sv
// Self-checking bench for ledr_pwm: directed plan items plus randomized duty/prescale/invert
// runs checked by per-period high-time arithmetic.
module tb_ledr_pwm;

    localparam int CH    = 10;
    localparam int PB    = 8;
    localparam int PSB   = 16;
    localparam int AW    = $clog2(CH + 3);
    localparam int PMAX  = (1 << PB) - 1;
    localparam int NPER  = 1 << PB;
    localparam int ACTRL = CH;
    localparam int APRE  = CH + 1;
    localparam int AMASK = CH + 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          chipselect = 1'b0;
    logic [AW-1:0] address = '0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic          read = 1'b0;
    logic [31:0]   readdata;
    logic [CH-1:0] ledr;

    int checks = 0;
    int errors = 0;
    int hc[CH];
    int m_duty[CH];

    ledr_pwm #(.CHANNELS(CH), .PWM_BITS(PB), .PRESCALE_BITS(PSB)) dut (
        .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .write(write), .writedata(writedata), .read(read), .readdata(readdata), .ledr(ledr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = AW'(a); writedata = 32'(d);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = AW'(a);
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic run_count(input int n);
        for (int c = 0; c < CH; c++) hc[c] = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (ledr[c]) hc[c]++;
        end
    endtask

    // Expected high clocks in one full period of (pre+1)*2^PB clocks.
    function automatic int exp_high(input int duty, input int pre, input bit inv);
        int len, hi;
        len = (pre + 1) * NPER;
        hi  = (duty == PMAX) ? len : duty * (pre + 1);
        return inv ? len - hi : hi;
    endfunction

    initial begin
        logic [31:0] rv;
        int          p3, sum, pre, len, cnt0, cnt1, hit;
        bit          inv;

        // Reset state
        #1 check("ledr_in_reset", 32'(ledr), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("readdata_reset", readdata, 32'd0);
        for (int a = 0; a <= CH + 2; a++) begin
            rd(a, rv);
            check($sformatf("reset_rd_%0d", a), rv, 32'd0);
        end
        repeat (20) @(negedge clk);
        check("ledr_after_reset", 32'(ledr), 32'd0);

        // Duty 64 at prescale 0 over four periods
        wr(APRE, 0); wr(0, 64); wr(ACTRL, 1);
        for (int p = 0; p < 4; p++) begin
            run_count(NPER);
            sum = 0;
            for (int c = 1; c < CH; c++) sum += hc[c];
            check($sformatf("duty64_p%0d", p), 32'(hc[0]), 32'd64);
            check($sformatf("others_off_p%0d", p), 32'(sum), 32'd0);
        end

        // Mid-period duty change takes effect at the next period
        wr(ACTRL, 0); wr(0, 0); wr(3, 64); wr(ACTRL, 1);
        cnt0 = 0; cnt1 = 0; rv = '0;
        for (int k = 1; k <= 2 * NPER; k++) begin
            @(negedge clk);
            if (ledr[3]) begin
                if (k <= NPER) cnt0++; else cnt1++;
            end
            if (k == 100) begin
                chipselect = 1'b1; write = 1'b1; address = AW'(3); writedata = 32'd192;
            end
            if (k == 101) begin
                write = 1'b0; read = 1'b1;
            end
            if (k == 102) begin
                rv = readdata;
                read = 1'b0; chipselect = 1'b0;
            end
        end
        check("midupd_cur_period", 32'(cnt0), 32'd64);
        check("midupd_next_period", 32'(cnt1), 32'd192);
        check("midupd_readback", rv, 32'd192);

        // Duty extremes, inversion, and disabled output
        wr(ACTRL, 0); wr(3, 0); wr(0, 0); wr(1, PMAX); wr(ACTRL, 1);
        run_count(NPER);
        check("duty0_off", 32'(hc[0]), 32'd0);
        check("dutymax_on", 32'(hc[1]), 32'(NPER));
        wr(ACTRL, 3);
        run_count(NPER);
        check("inv_duty0_on", 32'(hc[0]), 32'(NPER));
        check("inv_dutymax_off", 32'(hc[1]), 32'd0);
        wr(ACTRL, 2);
        @(negedge clk);
        check("en0_inv1_all_on", 32'(ledr), 32'h3FF);

        // Prescale 3, then asynchronous reset mid-period
        wr(ACTRL, 0); wr(1, 0); wr(APRE, 3); wr(9, 128); wr(ACTRL, 1);
        run_count(4 * NPER);
        check("pre3_duty128", 32'(hc[9]), 32'd512);
        hit = 0;
        for (int k = 0; k < 2000 && hit == 0; k++) begin
            @(negedge clk);
            if (ledr[9]) hit = 1;
        end
        check("pre3_high_seen", 32'(hit), 32'd1);
        #2 reset_n = 1'b0;
        #1 check("async_reset_ledr", 32'(ledr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a <= CH + 2; a++) begin
            rd(a, rv);
            check($sformatf("post_reset_rd_%0d", a), rv, 32'd0);
        end

        // Randomized duties, prescale and inversion
        for (int it = 0; it < 6; it++) begin
            pre = int'($urandom_range(0, 3));
            inv = 1'($urandom_range(0, 1));
            wr(ACTRL, 0);
            wr(APRE, pre);
            for (int c = 0; c < CH; c++) begin
                case ($urandom_range(0, 7))
                    0: m_duty[c] = 0;
                    1: m_duty[c] = PMAX;
                    default: m_duty[c] = int'($urandom_range(0, PMAX));
                endcase
                wr(c, m_duty[c]);
            end
            wr(ACTRL, inv ? 3 : 1);
            len = (pre + 1) * NPER;
            run_count(len);
            for (int c = 0; c < CH; c++)
                check($sformatf("rnd%0d_ch%0d_d%0d_p%0d_i%0d", it, c, m_duty[c], pre, inv),
                      32'(hc[c]), 32'(exp_high(m_duty[c], pre, inv)));
            p3 = int'($urandom_range(0, CH - 1));
            rd(p3, rv);
            check($sformatf("rnd%0d_rd_duty%0d", it, p3), rv, 32'(m_duty[p3]));
            rd(APRE, rv);
            check($sformatf("rnd%0d_rd_pre", it), rv, 32'(pre));
        end

`ifdef LEDR_PWM_BLINK_EN
        wr(ACTRL, 0);
        for (int c = 0; c < CH; c++) wr(c, 0);
        wr(0, PMAX); wr(APRE, 0); wr(AMASK, 1); wr(ACTRL, 1 | (1 << 8));
        for (int p = 0; p < 4; p++) begin
            run_count(2 * NPER);
            check($sformatf("blink_half%0d", p), 32'(hc[0]), (p % 2 == 0) ? 32'(2 * NPER) : 32'd0);
        end
`else
        wr(AMASK, 1);
        rd(AMASK, rv);
        check("unmapped_mask_rd", rv, 32'd0);
        wr(ACTRL, 32'h0000_FF00);
        rd(ACTRL, rv);
        check("ctrl_div_rd0", rv, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
